// File: rtl/product_bcd_converter_pkg.sv
// Shared types and constants for the product binary-to-BCD converter.
// State encoding, digit width and the add-3 threshold.
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [3:0] ADD3_TH = 4'd5;

endpackage

// File: rtl/product_bcd_converter_add3_cell.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Purely combinational, one instance per digit.
module bcd_add3_cell
  import product_bcd_converter_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= ADD3_TH) ? d + 4'd3 : d;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-add-3 converter from multiplier product to packed BCD.
// One iteration per clock, one conversion in flight, valid/ready on both sides.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] bcd
);

  localparam int BW = BCD_W * DIGITS;
  localparam int SW = BW + IN_W;
  localparam int CW = $clog2(IN_W + 1);

  state_t state, state_nx;

  logic [SW-1:0] sr;
  logic [SW-1:0] sr_shift;
  logic [BW-1:0] adj;
  logic [CW-1:0] count;
  logic          last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .d (sr[IN_W + g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

  assign sr_shift  = {adj, sr[IN_W-1:0]} << 1;
  assign last      = (count == CW'(IN_W - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // bcd is only written when a conversion completes, so it holds the
  // last result through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr    <= '0;
      count <= '0;
      bcd   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {{BW{1'b0}}, in_data};
            count <= '0;
          end
        end
        SHIFT: begin
          sr    <= sr_shift;
          count <= count + CW'(1);
          if (last) bcd <= sr_shift[SW-1 -: BW];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: latency, backpressure,
// back-to-back throughput, mid-conversion reset and a full 0..255 sweep.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat;
  int t1;
  int t2;
  int guard;

  product_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] v);
    chk("acc_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    do begin
      step();
      l++;
    end while (!out_valid && l < 40);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bcd", 32'(bcd), 32'h000);
    rst_n = 1'b1;
    step();

    // zero input, normal latency, one-cycle valid
    accept(8'd0);
    chk("zero_busy", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("zero_lat", 32'(lat), 32'd8);
    chk("zero_bcd", 32'(bcd), 32'h000);
    step();
    chk("zero_valid_drop", 32'(out_valid), 32'd0);
    chk("zero_idle", 32'(in_ready), 32'd1);

    accept(8'd225);
    wait_done(lat);
    chk("p225_lat", 32'(lat), 32'd8);
    chk("p225_bcd", 32'(bcd), 32'h225);
    step();

    accept(8'd255);
    wait_done(lat);
    chk("p255_bcd", 32'(bcd), 32'h255);
    step();
    chk("p255_hold_after", 32'(bcd), 32'h255);

    accept(8'd99);
    wait_done(lat);
    chk("p99_bcd", 32'(bcd), 32'h099);
    step();

    // backpressure, with noise on the input side
    out_ready = 1'b0;
    accept(8'd42);
    wait_done(lat);
    chk("bp_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'(i & 1);
      in_data  = 8'(i * 13);
      chk("bp_bcd", 32'(bcd), 32'h042);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_bcd_kept", 32'(bcd), 32'h042);

    // back-to-back with in_valid held high
    in_valid = 1'b1;
    in_data  = 8'd7;
    step();
    t1 = cyc;
    in_data = 8'd130;
    wait_done(lat);
    chk("b2b_lat1", 32'(lat), 32'd8);
    chk("b2b_bcd1", 32'(bcd), 32'h007);
    guard = 0;
    while (!in_ready && guard < 40) begin
      step();
      guard++;
    end
    chk("b2b_idle_seen", 32'(in_ready), 32'd1);
    step();
    t2 = cyc;
    in_valid = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'd10);
    wait_done(lat);
    chk("b2b_lat2", 32'(lat), 32'd8);
    chk("b2b_bcd2", 32'(bcd), 32'h130);
    step();

    // reset during iteration 4 aborts the conversion
    accept(8'd200);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h000);
    chk("abort_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    accept(8'd200);
    wait_done(lat);
    chk("redo_lat", 32'(lat), 32'd8);
    chk("redo_bcd", 32'(bcd), 32'h200);
    step();

    for (int v = 0; v < 256; v++) begin
      accept(8'(v));
      wait_done(lat);
      chk("sweep_lat", 32'(lat), 32'd8);
      chk("sweep_bcd", 32'(bcd), 32'(ref_bcd(v)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
